// File: rtl/dmi_pkg.sv
// Shared DMI definitions: bus widths, op and response encodings, responder FSM states.
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

    localparam logic [1:0] DMI_RSP_OK     = 2'd0;
    localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        DMI_ST_IDLE = 2'd0,
        DMI_ST_WAIT = 2'd1,
        DMI_ST_RESP = 2'd2
    } dmi_state_e;

endpackage

// File: rtl/dmi_reg_bank.sv
// Scratch register array: synchronous write, combinational read, synchronous clear.
module dmi_reg_bank
    import dmi_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_we,
    input  logic [DMI_ADDR_W-1:0] i_idx,
    input  logic [DMI_DATA_W-1:0] i_wdata,
    output logic [DMI_DATA_W-1:0] o_rdata
);

    localparam int                    IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [DMI_ADDR_W-1:0] LIMIT = DMI_ADDR_W'(NUM_REGS);

    logic [DMI_DATA_W-1:0] r_regs [NUM_REGS];
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;

    // Out-of-range indices read as zero and never write, even for non-power-of-two sizes.
    assign w_in_range = (i_idx < LIMIT);
    assign w_idx      = i_idx[IDX_W-1:0];
    assign o_rdata    = w_in_range ? r_regs[w_idx] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && w_in_range) begin
            r_regs[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/dmi_reg_responder.sv
// DMI target endpoint: scratch register bank plus saturating access counter,
// one outstanding request, response delayed by a programmable number of cycles.
module dmi_reg_responder
    import dmi_pkg::*;
#(
    parameter int                    NUM_REGS    = 8,
    parameter logic [DMI_ADDR_W-1:0] BASE_ADDR   = 7'h04,
    parameter logic [DMI_ADDR_W-1:0] STATUS_ADDR = 7'h7F,
    parameter int                    RSP_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  dmi_req_valid,
    output logic                  dmi_req_ready,
    input  logic [DMI_ADDR_W-1:0] dmi_req_addr,
    input  logic [DMI_DATA_W-1:0] dmi_req_data,
    input  logic [1:0]            dmi_req_op,
    output logic                  dmi_rsp_valid,
    input  logic                  dmi_rsp_ready,
    output logic [DMI_DATA_W-1:0] dmi_rsp_data,
    output logic [1:0]            dmi_rsp_response,
    output logic [15:0]           access_count
);

    if (RSP_LATENCY < 0 || RSP_LATENCY > 15 || NUM_REGS < 1 || NUM_REGS > 64 ||
        int'(BASE_ADDR) + NUM_REGS > 128 ||
        (int'(STATUS_ADDR) >= int'(BASE_ADDR) &&
         int'(STATUS_ADDR) < int'(BASE_ADDR) + NUM_REGS)) begin : g_bad_params
        $fatal(1, "dmi_reg_responder: illegal parameter combination");
    end

    localparam logic [3:0] LAT_LOAD = 4'(RSP_LATENCY);
    localparam logic [7:0] BANK_LO  = {1'b0, BASE_ADDR};
    localparam logic [7:0] BANK_HI  = BANK_LO + 8'(NUM_REGS);

    dmi_state_e             r_state, w_state_next;
    logic [3:0]             r_cnt, w_cnt_next;
    logic                   w_accept, w_exec;
    logic [DMI_ADDR_W-1:0]  r_addr;
    logic [DMI_DATA_W-1:0]  r_wdata;
    logic [1:0]             r_op;
    logic                   r_rsp_valid;
    logic [DMI_DATA_W-1:0]  r_rsp_data;
    logic [1:0]             r_rsp_response;
    logic [15:0]            r_access_count;

    logic                   w_in_bank, w_is_status;
    logic [DMI_ADDR_W-1:0]  w_bank_idx;
    logic [DMI_DATA_W-1:0]  w_bank_rdata;
    logic [DMI_DATA_W-1:0]  w_dec_data;
    logic [1:0]             w_dec_resp;
    logic                   w_dec_we, w_dec_count;

    assign dmi_req_ready    = (r_state == DMI_ST_IDLE) && !RST;
    assign dmi_rsp_valid    = r_rsp_valid;
    assign dmi_rsp_data     = r_rsp_data;
    assign dmi_rsp_response = r_rsp_response;
    assign access_count     = r_access_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= DMI_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // WAIT always lasts RSP_LATENCY+1 cycles, so a request accepted at edge N
    // executes and raises rsp_valid at edge N+1+RSP_LATENCY, including latency 0.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            DMI_ST_IDLE: begin
                if (dmi_req_valid && dmi_req_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = DMI_ST_WAIT;
                    w_cnt_next   = LAT_LOAD;
                end
            end
            DMI_ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_exec       = 1'b1;
                    w_state_next = DMI_ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            DMI_ST_RESP: begin
                if (dmi_rsp_ready) begin
                    w_state_next = DMI_ST_IDLE;
                end
            end
            default: w_state_next = DMI_ST_IDLE;
        endcase
    end

    assign w_in_bank   = ({1'b0, r_addr} >= BANK_LO) && ({1'b0, r_addr} < BANK_HI);
    assign w_is_status = (r_addr == STATUS_ADDR);
    assign w_bank_idx  = r_addr - BASE_ADDR;

    always_comb begin
        w_dec_data  = '0;
        w_dec_resp  = DMI_RSP_OK;
        w_dec_we    = 1'b0;
        w_dec_count = 1'b0;
        case (r_op)
            DMI_OP_NOP: ;
            DMI_OP_READ: begin
                if (w_in_bank) begin
                    w_dec_data  = w_bank_rdata;
                    w_dec_count = 1'b1;
                end else if (w_is_status) begin
                    w_dec_data  = {16'd0, r_access_count};
                    w_dec_count = 1'b1;
                end else begin
                    w_dec_resp = DMI_RSP_FAILED;
                end
            end
            DMI_OP_WRITE: begin
                if (w_in_bank) begin
                    w_dec_we    = 1'b1;
                    w_dec_count = 1'b1;
                end else begin
                    w_dec_resp = DMI_RSP_FAILED;
                end
            end
            default: w_dec_resp = DMI_RSP_FAILED;
        endcase
    end

    // Read data is taken from the bank before the same edge's write lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_op           <= DMI_OP_NOP;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_response <= DMI_RSP_OK;
            r_access_count <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= dmi_req_addr;
                r_wdata <= dmi_req_data;
                r_op    <= dmi_req_op;
            end
            if (w_exec) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_data     <= w_dec_data;
                r_rsp_response <= w_dec_resp;
                if (w_dec_count && (r_access_count != 16'hFFFF)) begin
                    r_access_count <= r_access_count + 16'd1;
                end
            end else if ((r_state == DMI_ST_RESP) && dmi_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    dmi_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .CLK     (CLK),
        .RST     (RST),
        .i_we    (w_exec && w_dec_we),
        .i_idx   (w_bank_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_bank_rdata)
    );

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Bench for dmi_reg_responder: directed and randomized DMI transactions on a latency-2
// and a latency-0 instance, checked against an address-map model of the register file.
module tb_dmi_reg_responder;
    import dmi_pkg::*;

    localparam int         NUM_REGS = 8;
    localparam logic [6:0] BASE     = 7'h04;
    localparam logic [6:0] STATUS   = 7'h7F;
    localparam int         LAT0     = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        reqValid0, reqReady0, rspValid0, rspReady0;
    logic [6:0]  reqAddr0;
    logic [31:0] reqData0, rspData0;
    logic [1:0]  reqOp0, rspResp0;
    logic [15:0] accessCount0;

    logic        reqValid1, reqReady1, rspValid1;
    logic        rspReady1 = 1'b1;
    logic [6:0]  reqAddr1;
    logic [31:0] reqData1, rspData1;
    logic [1:0]  reqOp1, rspResp1;
    logic [15:0] accessCount1;

    dmi_reg_responder #(
        .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .STATUS_ADDR(STATUS), .RSP_LATENCY(LAT0)
    ) u_dut0 (
        .CLK(clk), .RST(rst),
        .dmi_req_valid(reqValid0), .dmi_req_ready(reqReady0),
        .dmi_req_addr(reqAddr0), .dmi_req_data(reqData0), .dmi_req_op(reqOp0),
        .dmi_rsp_valid(rspValid0), .dmi_rsp_ready(rspReady0),
        .dmi_rsp_data(rspData0), .dmi_rsp_response(rspResp0),
        .access_count(accessCount0)
    );

    dmi_reg_responder #(
        .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .STATUS_ADDR(STATUS), .RSP_LATENCY(0)
    ) u_dut1 (
        .CLK(clk), .RST(rst),
        .dmi_req_valid(reqValid1), .dmi_req_ready(reqReady1),
        .dmi_req_addr(reqAddr1), .dmi_req_data(reqData1), .dmi_req_op(reqOp1),
        .dmi_rsp_valid(rspValid1), .dmi_rsp_ready(rspReady1),
        .dmi_rsp_data(rspData1), .dmi_rsp_response(rspResp1),
        .access_count(accessCount1)
    );

    int compCount = 0;
    int mismCount = 0;
    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    logic [31:0] modelRegs [2][NUM_REGS];
    int          modelCount [2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            mismCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int n = 0; n < 2; n++) begin
            modelCount[n] = 0;
            for (int i = 0; i < NUM_REGS; i++) modelRegs[n][i] = '0;
        end
    endtask

    // Address map: bank at BASE..BASE+NUM_REGS-1, status at STATUS, everything else fails.
    task automatic modelExec(input int inst, input logic [1:0] op, input logic [6:0] addr,
                             input logic [31:0] data, output logic [31:0] expData,
                             output logic [1:0] expResp);
        int  a;
        bit  inBank, isStatus, bump;
        a        = int'(addr);
        inBank   = (a >= int'(BASE)) && (a < int'(BASE) + NUM_REGS);
        isStatus = (a == int'(STATUS));
        expData  = 32'd0;
        expResp  = 2'd2;
        bump     = 1'b0;
        if (op == 2'd0) begin
            expResp = 2'd0;
        end else if (op == 2'd1 && inBank) begin
            expData = modelRegs[inst][a - int'(BASE)];
            expResp = 2'd0;
            bump    = 1'b1;
        end else if (op == 2'd1 && isStatus) begin
            expData = 32'(modelCount[inst]);
            expResp = 2'd0;
            bump    = 1'b1;
        end else if (op == 2'd2 && inBank) begin
            modelRegs[inst][a - int'(BASE)] = data;
            expResp = 2'd0;
            bump    = 1'b1;
        end
        if (bump && modelCount[inst] < 65535) modelCount[inst]++;
    endtask

    // One transaction on the latency-2 instance; entered and left at a negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr,
                                 input logic [31:0] data, input int holdCycles,
                                 input string tag);
        logic [31:0] expData;
        logic [1:0]  expResp;
        int          j;
        checkOutput({tag, ".reqReadyIdle"}, 32'(reqReady0), 32'd1);
        reqValid0 = 1'b1; reqOp0 = op; reqAddr0 = addr; reqData0 = data;
        @(posedge clk);
        @(negedge clk);
        reqValid0 = 1'b0; reqOp0 = 2'd0; reqAddr0 = '0; reqData0 = '0;
        modelExec(0, op, addr, data, expData, expResp);
        j = 0;
        while (!rspValid0 && j < 40) begin
            @(negedge clk);
            j++;
        end
        checkOutput({tag, ".latency"}, 32'(j), 32'(1 + LAT0));
        checkOutput({tag, ".data"}, rspData0, expData);
        checkOutput({tag, ".resp"}, 32'(rspResp0), 32'(expResp));
        checkOutput({tag, ".count"}, 32'(accessCount0), 32'(modelCount[0]));
        checkOutput({tag, ".reqReadyBusy"}, 32'(reqReady0), 32'd0);
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput({tag, ".holdValid"}, 32'(rspValid0), 32'd1);
            checkOutput({tag, ".holdData"}, rspData0, expData);
            checkOutput({tag, ".holdResp"}, 32'(rspResp0), 32'(expResp));
            checkOutput({tag, ".holdReqReady"}, 32'(reqReady0), 32'd0);
        end
        rspReady0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady0 = 1'b0;
        checkOutput({tag, ".validDrop"}, 32'(rspValid0), 32'd0);
        checkOutput({tag, ".reqReadyBack"}, 32'(reqReady0), 32'd1);
    endtask

    // One transaction on the latency-0 instance with rsp_ready tied high; leaves valid asserted.
    task automatic applyStimulusLat0(input logic [1:0] op, input logic [6:0] addr,
                                     input logic [31:0] data, input string tag,
                                     output int acceptCycle);
        logic [31:0] expData;
        logic [1:0]  expResp;
        int          w;
        reqValid1 = 1'b1; reqOp1 = op; reqAddr1 = addr; reqData1 = data;
        w = 0;
        while (!reqReady1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, ".reqReady"}, 32'(reqReady1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        acceptCycle = cycleCount;
        modelExec(1, op, addr, data, expData, expResp);
        checkOutput({tag, ".earlyValid"}, 32'(rspValid1), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".valid"}, 32'(rspValid1), 32'd1);
        checkOutput({tag, ".data"}, rspData1, expData);
        checkOutput({tag, ".resp"}, 32'(rspResp1), 32'(expResp));
        checkOutput({tag, ".count"}, 32'(accessCount1), 32'(modelCount[1]));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          sawValid;
        int          prevAccept, thisAccept;
        logic [1:0]  rOp;
        logic [6:0]  rAddr;
        logic [31:0] rData;

        rst = 1'b1;
        reqValid0 = 1'b0; reqOp0 = '0; reqAddr0 = '0; reqData0 = '0; rspReady0 = 1'b0;
        reqValid1 = 1'b0; reqOp1 = '0; reqAddr1 = '0; reqData1 = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.reqReady", 32'(reqReady0), 32'd0);
        checkOutput("reset.rspValid", 32'(rspValid0), 32'd0);
        checkOutput("reset.rspData", rspData0, 32'd0);
        checkOutput("reset.rspResp", 32'(rspResp0), 32'd0);
        checkOutput("reset.count", 32'(accessCount0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2'd2, BASE + 7'd3, 32'hDEADBEEF, 0, "wrBase3");
        applyStimulus(2'd1, BASE + 7'd3, 32'h0, 0, "rdBase3");
        checkOutput("rdBase3.value", rspData0, 32'hDEADBEEF);
        applyStimulus(2'd1, 7'h7F, 32'h0, 0, "rdStatus");
        checkOutput("rdStatus.value", rspData0, 32'h00000002);
        applyStimulus(2'd2, 7'h7F, 32'hFFFF0000, 0, "wrStatus");
        checkOutput("wrStatus.count", 32'(accessCount0), 32'd3);
        applyStimulus(2'd1, 7'h03, 32'h0, 0, "rdLow");
        applyStimulus(2'd1, 7'h0C, 32'h0, 0, "rdHigh");
        applyStimulus(2'd3, BASE, 32'h5A5A5A5A, 0, "opRsvd");
        checkOutput("opRsvd.count", 32'(accessCount0), 32'd3);
        applyStimulus(2'd1, BASE + 7'd3, 32'h0, 10, "holdRd");

        // Reset while the write sits in WAIT: it must vanish without a response.
        reqValid0 = 1'b1; reqOp0 = 2'd2; reqAddr0 = BASE; reqData0 = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reqValid0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midReset.reqReady", 32'(reqReady0), 32'd0);
        rst = 1'b0;
        modelReset();
        sawValid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rspValid0) sawValid++;
        end
        checkOutput("midReset.noRsp", 32'(sawValid), 32'd0);
        applyStimulus(2'd1, BASE, 32'h0, 0, "postReset");
        checkOutput("postReset.count", 32'(accessCount0), 32'd1);

        for (int k = 0; k < 30; k++) begin
            int sel;
            sel = $urandom_range(0, 3);
            rOp = 2'($urandom_range(0, 3));
            if (sel < 2)       rAddr = BASE + 7'($urandom_range(0, NUM_REGS - 1));
            else if (sel == 2) rAddr = STATUS;
            else               rAddr = 7'($urandom_range(0, 127));
            rData = $urandom;
            applyStimulus(rOp, rAddr, rData, $urandom_range(0, 3), $sformatf("rand%0d", k));
        end

        prevAccept = 0;
        for (int k = 0; k < 8; k++) begin
            rOp   = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            rAddr = ($urandom_range(0, 4) == 0) ? STATUS
                                                 : BASE + 7'($urandom_range(0, NUM_REGS - 1));
            rData = $urandom;
            applyStimulusLat0(rOp, rAddr, rData, $sformatf("lat0_%0d", k), thisAccept);
            if (k > 0) checkOutput($sformatf("lat0_%0d.spacing", k),
                                   32'(thisAccept - prevAccept), 32'd3);
            prevAccept = thisAccept;
        end
        reqValid1 = 1'b0;
        repeat (3) @(negedge clk);

        force u_dut1.r_access_count = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release u_dut1.r_access_count;
        modelCount[1] = 65535;
        @(negedge clk);
        checkOutput("sat.forced", 32'(accessCount1), 32'h0000FFFF);
        applyStimulusLat0(2'd1, BASE, 32'h0, "satRead", thisAccept);
        checkOutput("satRead.hold", 32'(accessCount1), 32'h0000FFFF);
        applyStimulusLat0(2'd1, STATUS, 32'h0, "satStatus", thisAccept);
        checkOutput("satStatus.value", rspData1, 32'h0000FFFF);
        reqValid1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, mismCount);
        $finish;
    end

endmodule
